axi_slave_decerr: RTL and testbench
===================================

// Module: axi_slave_decerr
// PURPOSE
//  Interconnect error sink that sits on the slave port behind the address decoder and receives every burst whose address matches no slave.
//  Fully completes each AXI burst with an error response, so an unmapped access never hangs the master.
//  Unlike a tie-off stub, it handshakes every channel. Independent write and read FSMs; one outstanding burst per direction.
// PARAMETERS
//  ID_WIDTH    4      transaction ID width
//  DATA_WIDTH  32     data bus width; strobe width = DATA_WIDTH/8
//  RESP_CODE   2'b11  response returned on B and R (DECERR)
// PORTS
//  clk                  in   1           clock
//  rstn                 in   1           asynchronous active-low reset
//  SLAVE_WR_ADDR_ID     in   ID_WIDTH    write burst ID, captured
//  SLAVE_WR_ADDR_LEN    in   8           write beats-1 (used only for mismatch check)
//  SLAVE_WR_ADDR_VALID  in   1           AW valid
//  SLAVE_WR_ADDR_READY  out  1           AW ready
//  SLAVE_WR_DATA_LAST   in   1           last write beat
//  SLAVE_WR_DATA_VALID  in   1           W valid
//  SLAVE_WR_DATA_READY  out  1           W ready
//  SLAVE_WR_BACK_ID     out  ID_WIDTH    B ID = captured AW ID
//  SLAVE_WR_BACK_RESP   out  2           B response
//  SLAVE_WR_BACK_VALID  out  1           B valid
//  SLAVE_WR_BACK_READY  in   1           B ready
//  SLAVE_RD_ADDR_ID     in   ID_WIDTH    read burst ID, captured
//  SLAVE_RD_ADDR_LEN    in   8           read beats-1, captured
//  SLAVE_RD_ADDR_VALID  in   1           AR valid
//  SLAVE_RD_ADDR_READY  out  1           AR ready
//  SLAVE_RD_BACK_ID     out  ID_WIDTH    R ID = captured AR ID
//  SLAVE_RD_DATA        out  DATA_WIDTH  R data, constant 0
//  SLAVE_RD_DATA_RESP   out  2           R response
//  SLAVE_RD_DATA_LAST   out  1           last read beat
//  SLAVE_RD_DATA_VALID  out  1           R valid
//  SLAVE_RD_DATA_READY  in   1           R ready
//  SLAVE_WR_ADDR[31:0], SLAVE_WR_ADDR_BURST[1:0], SLAVE_WR_DATA, SLAVE_WR_STRB  in  ignored
//  SLAVE_RD_ADDR[31:0], SLAVE_RD_ADDR_BURST[1:0]  in  ignored
//  WR_LEN_ERR           out  1           sticky: a write burst's beat count != AW LEN+1
// BEHAVIOUR
//  Reset (rstn low, async): both FSMs go to IDLE; all outputs 0, incl. READYs, IDs, counters and WR_LEN_ERR. This also holds mid-burst.
//  All outputs are registered or decoded from FSM state only. No combinational path from inputs to outputs.
//  Write FSM W_IDLE -> W_DATA -> W_RESP:
//   - W_IDLE: AW_READY=1 and W_READY=0. On AW handshake, capture ID and LEN, clear beat count, go to W_DATA.
//   - W_DATA: W_READY=1. Each W handshake increments the count. W beats that arrive in W_IDLE stay stalled.
//   - The handshake with LAST=1 ends the burst; go to W_RESP.
//   - If the count incl. this beat != LEN+1, set WR_LEN_ERR. LAST is authoritative and LEN never terminates the burst.
//   - W_RESP: BACK_VALID=1, BACK_ID=captured ID, RESP=RESP_CODE. Hold stable until BACK_READY, then return to W_IDLE.
//   - Next AW is accepted the cycle after the B handshake.
//  Read FSM R_IDLE -> R_DATA:
//   - R_IDLE: AR_READY=1. On AR handshake at cycle N, capture ID and LEN, beat count=0.
//   - R_DATA from N+1: DATA_VALID=1, DATA=0, RESP=RESP_CODE, BACK_ID=captured ID, LAST=(count==LEN).
//   - Count increments only on R handshake. VALID/DATA/LAST are stable while READY is low.
//   - After the LAST handshake, return to R_IDLE (VALID=0 the next cycle).
//   - LEN=255 yields exactly 256 beats; the 8-bit count never wraps mid-burst.
//  Write and read FSMs are fully independent. Simultaneous AW and AR handshakes in the same cycle are both accepted.
//  WR_LEN_ERR clears only on reset.
// TESTING
//  - AW ID=5 LEN=3, 4 W beats with LAST on the 4th, BREADY=1 -> B ID=5 RESP=2'b11 one cycle after LAST; WR_LEN_ERR=0.
//  - AR ID=9 LEN=0, RREADY=1 -> single beat, DATA=0, LAST=1, RESP=11, ID=9 at N+1; AR_READY is 1 again at N+2.
//  - AR LEN=255 with RREADY toggled randomly -> exactly 256 beats, LAST only on the 256th, outputs stable while stalled.
//  - AW LEN=3, LAST on the 2nd beat -> B issued after beat 2; WR_LEN_ERR=1 and it stays 1.
//  - AW and AR in the same cycle, BREADY held 0 for 10 cycles -> read burst completes unaffected; B held stable until BREADY.
//  - rstn pulled low mid read burst (beat 2 of 8) -> all outputs 0 asynchronously; a new AR after release starts at beat 0.

Source files
------------

// File: rtl/axi_slave_decerr.sv
// AXI error sink for unmapped addresses: handshakes every channel and completes
// each burst with RESP_CODE; independent write/read FSMs, one burst in flight each.
module axi_slave_decerr #(
    parameter int         ID_WIDTH   = 4,
    parameter int         DATA_WIDTH = 32,
    parameter logic [1:0] RESP_CODE  = 2'b11
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [ID_WIDTH-1:0]     SLAVE_WR_ADDR_ID,
    input  logic [31:0]             SLAVE_WR_ADDR,
    input  logic [7:0]              SLAVE_WR_ADDR_LEN,
    input  logic [1:0]              SLAVE_WR_ADDR_BURST,
    input  logic                    SLAVE_WR_ADDR_VALID,
    output logic                    SLAVE_WR_ADDR_READY,
    input  logic [DATA_WIDTH-1:0]   SLAVE_WR_DATA,
    input  logic [DATA_WIDTH/8-1:0] SLAVE_WR_STRB,
    input  logic                    SLAVE_WR_DATA_LAST,
    input  logic                    SLAVE_WR_DATA_VALID,
    output logic                    SLAVE_WR_DATA_READY,
    output logic [ID_WIDTH-1:0]     SLAVE_WR_BACK_ID,
    output logic [1:0]              SLAVE_WR_BACK_RESP,
    output logic                    SLAVE_WR_BACK_VALID,
    input  logic                    SLAVE_WR_BACK_READY,
    input  logic [ID_WIDTH-1:0]     SLAVE_RD_ADDR_ID,
    input  logic [31:0]             SLAVE_RD_ADDR,
    input  logic [7:0]              SLAVE_RD_ADDR_LEN,
    input  logic [1:0]              SLAVE_RD_ADDR_BURST,
    input  logic                    SLAVE_RD_ADDR_VALID,
    output logic                    SLAVE_RD_ADDR_READY,
    output logic [ID_WIDTH-1:0]     SLAVE_RD_BACK_ID,
    output logic [DATA_WIDTH-1:0]   SLAVE_RD_DATA,
    output logic [1:0]              SLAVE_RD_DATA_RESP,
    output logic                    SLAVE_RD_DATA_LAST,
    output logic                    SLAVE_RD_DATA_VALID,
    input  logic                    SLAVE_RD_DATA_READY,
    output logic                    WR_LEN_ERR
);

    // state  | meaning
    // W_IDLE | waiting for AW        W_DATA | sinking W beats until LAST
    // W_RESP | B valid until ready   R_IDLE | waiting for AR
    // R_DATA | returning error beats until the LAST handshake
    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic       R_IDLE = 1'b0;
    localparam logic       R_DATA = 1'b1;

    logic [1:0]          r_wstate;
    logic                r_aw_ready;
    logic                r_w_ready;
    logic                r_b_valid;
    logic [ID_WIDTH-1:0] r_b_id;
    logic [7:0]          r_w_len;
    logic [8:0]          r_w_cnt;
    logic                r_len_err;

    logic                r_rstate;
    logic                r_ar_ready;
    logic                r_r_valid;
    logic                r_r_last;
    logic [ID_WIDTH-1:0] r_r_id;
    logic [7:0]          r_r_len;
    logic [7:0]          r_r_cnt;

    logic                w_unused;

    assign w_unused = ^{SLAVE_WR_ADDR, SLAVE_WR_ADDR_BURST, SLAVE_WR_DATA, SLAVE_WR_STRB,
                        SLAVE_RD_ADDR, SLAVE_RD_ADDR_BURST};

    // Beat counter saturates at 256 so an over-long burst still mismatches LEN+1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wstate   <= W_IDLE;
            r_aw_ready <= 1'b0;
            r_w_ready  <= 1'b0;
            r_b_valid  <= 1'b0;
            r_b_id     <= '0;
            r_w_len    <= '0;
            r_w_cnt    <= '0;
            r_len_err  <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (SLAVE_WR_ADDR_VALID && r_aw_ready) begin
                        r_b_id     <= SLAVE_WR_ADDR_ID;
                        r_w_len    <= SLAVE_WR_ADDR_LEN;
                        r_w_cnt    <= '0;
                        r_aw_ready <= 1'b0;
                        r_w_ready  <= 1'b1;
                        r_wstate   <= W_DATA;
                    end else begin
                        r_aw_ready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (SLAVE_WR_DATA_VALID && r_w_ready) begin
                        if (r_w_cnt != 9'd256)
                            r_w_cnt <= r_w_cnt + 9'd1;
                        if (SLAVE_WR_DATA_LAST) begin
                            r_w_ready <= 1'b0;
                            r_b_valid <= 1'b1;
                            r_wstate  <= W_RESP;
                            if (r_w_cnt != {1'b0, r_w_len})
                                r_len_err <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (SLAVE_WR_BACK_READY) begin
                        r_b_valid  <= 1'b0;
                        r_aw_ready <= 1'b1;
                        r_wstate   <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rstate   <= R_IDLE;
            r_ar_ready <= 1'b0;
            r_r_valid  <= 1'b0;
            r_r_last   <= 1'b0;
            r_r_id     <= '0;
            r_r_len    <= '0;
            r_r_cnt    <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (SLAVE_RD_ADDR_VALID && r_ar_ready) begin
                        r_r_id     <= SLAVE_RD_ADDR_ID;
                        r_r_len    <= SLAVE_RD_ADDR_LEN;
                        r_r_cnt    <= '0;
                        r_ar_ready <= 1'b0;
                        r_r_valid  <= 1'b1;
                        r_r_last   <= (SLAVE_RD_ADDR_LEN == 8'd0);
                        r_rstate   <= R_DATA;
                    end else begin
                        r_ar_ready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (SLAVE_RD_DATA_READY) begin
                        if (r_r_last) begin
                            r_r_valid  <= 1'b0;
                            r_r_last   <= 1'b0;
                            r_ar_ready <= 1'b1;
                            r_rstate   <= R_IDLE;
                        end else begin
                            r_r_cnt  <= r_r_cnt + 8'd1;
                            r_r_last <= ((r_r_cnt + 8'd1) == r_r_len);
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign SLAVE_WR_ADDR_READY = r_aw_ready;
    assign SLAVE_WR_DATA_READY = r_w_ready;
    assign SLAVE_WR_BACK_ID    = r_b_id;
    assign SLAVE_WR_BACK_RESP  = r_b_valid ? RESP_CODE : 2'b00;
    assign SLAVE_WR_BACK_VALID = r_b_valid;
    assign SLAVE_RD_ADDR_READY = r_ar_ready;
    assign SLAVE_RD_BACK_ID    = r_r_id;
    assign SLAVE_RD_DATA       = '0;
    assign SLAVE_RD_DATA_RESP  = r_r_valid ? RESP_CODE : 2'b00;
    assign SLAVE_RD_DATA_LAST  = r_r_last;
    assign SLAVE_RD_DATA_VALID = r_r_valid;
    assign WR_LEN_ERR          = r_len_err;

endmodule

// File: tb/tb_axi_slave_decerr.sv
// Bench for axi_slave_decerr: directed and randomized bursts checked against a
// transaction-level model (beats = LEN+1, sticky length-error flag).
module tb_axi_slave_decerr;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  SLAVE_WR_ADDR_ID = '0;
    logic [31:0] SLAVE_WR_ADDR = '0;
    logic [7:0]  SLAVE_WR_ADDR_LEN = '0;
    logic [1:0]  SLAVE_WR_ADDR_BURST = '0;
    logic        SLAVE_WR_ADDR_VALID = 1'b0;
    logic        SLAVE_WR_ADDR_READY;
    logic [31:0] SLAVE_WR_DATA = '0;
    logic [3:0]  SLAVE_WR_STRB = '0;
    logic        SLAVE_WR_DATA_LAST = 1'b0;
    logic        SLAVE_WR_DATA_VALID = 1'b0;
    logic        SLAVE_WR_DATA_READY;
    logic [3:0]  SLAVE_WR_BACK_ID;
    logic [1:0]  SLAVE_WR_BACK_RESP;
    logic        SLAVE_WR_BACK_VALID;
    logic        SLAVE_WR_BACK_READY = 1'b0;
    logic [3:0]  SLAVE_RD_ADDR_ID = '0;
    logic [31:0] SLAVE_RD_ADDR = '0;
    logic [7:0]  SLAVE_RD_ADDR_LEN = '0;
    logic [1:0]  SLAVE_RD_ADDR_BURST = '0;
    logic        SLAVE_RD_ADDR_VALID = 1'b0;
    logic        SLAVE_RD_ADDR_READY;
    logic [3:0]  SLAVE_RD_BACK_ID;
    logic [31:0] SLAVE_RD_DATA;
    logic [1:0]  SLAVE_RD_DATA_RESP;
    logic        SLAVE_RD_DATA_LAST;
    logic        SLAVE_RD_DATA_VALID;
    logic        SLAVE_RD_DATA_READY = 1'b0;
    logic        WR_LEN_ERR;

    int n_cmp = 0;
    int n_bad = 0;
    logic err_model = 1'b0;

    axi_slave_decerr #(.ID_WIDTH(4), .DATA_WIDTH(32), .RESP_CODE(2'b11)) dut (
        .clk(clk), .rstn(rstn),
        .SLAVE_WR_ADDR_ID(SLAVE_WR_ADDR_ID), .SLAVE_WR_ADDR(SLAVE_WR_ADDR),
        .SLAVE_WR_ADDR_LEN(SLAVE_WR_ADDR_LEN), .SLAVE_WR_ADDR_BURST(SLAVE_WR_ADDR_BURST),
        .SLAVE_WR_ADDR_VALID(SLAVE_WR_ADDR_VALID), .SLAVE_WR_ADDR_READY(SLAVE_WR_ADDR_READY),
        .SLAVE_WR_DATA(SLAVE_WR_DATA), .SLAVE_WR_STRB(SLAVE_WR_STRB),
        .SLAVE_WR_DATA_LAST(SLAVE_WR_DATA_LAST), .SLAVE_WR_DATA_VALID(SLAVE_WR_DATA_VALID),
        .SLAVE_WR_DATA_READY(SLAVE_WR_DATA_READY), .SLAVE_WR_BACK_ID(SLAVE_WR_BACK_ID),
        .SLAVE_WR_BACK_RESP(SLAVE_WR_BACK_RESP), .SLAVE_WR_BACK_VALID(SLAVE_WR_BACK_VALID),
        .SLAVE_WR_BACK_READY(SLAVE_WR_BACK_READY), .SLAVE_RD_ADDR_ID(SLAVE_RD_ADDR_ID),
        .SLAVE_RD_ADDR(SLAVE_RD_ADDR), .SLAVE_RD_ADDR_LEN(SLAVE_RD_ADDR_LEN),
        .SLAVE_RD_ADDR_BURST(SLAVE_RD_ADDR_BURST), .SLAVE_RD_ADDR_VALID(SLAVE_RD_ADDR_VALID),
        .SLAVE_RD_ADDR_READY(SLAVE_RD_ADDR_READY), .SLAVE_RD_BACK_ID(SLAVE_RD_BACK_ID),
        .SLAVE_RD_DATA(SLAVE_RD_DATA), .SLAVE_RD_DATA_RESP(SLAVE_RD_DATA_RESP),
        .SLAVE_RD_DATA_LAST(SLAVE_RD_DATA_LAST), .SLAVE_RD_DATA_VALID(SLAVE_RD_DATA_VALID),
        .SLAVE_RD_DATA_READY(SLAVE_RD_DATA_READY), .WR_LEN_ERR(WR_LEN_ERR)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {13'd0, SLAVE_WR_ADDR_READY, SLAVE_WR_DATA_READY, SLAVE_WR_BACK_ID,
                SLAVE_WR_BACK_RESP, SLAVE_WR_BACK_VALID, SLAVE_RD_ADDR_READY,
                SLAVE_RD_BACK_ID, SLAVE_RD_DATA, SLAVE_RD_DATA_RESP, SLAVE_RD_DATA_LAST,
                SLAVE_RD_DATA_VALID, WR_LEN_ERR};
    endfunction

    // Write burst of nbeats (LAST on the final one), B held off for bdelay cycles.
    task automatic do_write(input logic [3:0] id, input logic [7:0] len, input int nbeats,
                            input int bdelay);
        int k;
        @(negedge clk);
        SLAVE_WR_ADDR_VALID = 1'b1;
        SLAVE_WR_ADDR_ID    = id;
        SLAVE_WR_ADDR_LEN   = len;
        SLAVE_WR_ADDR       = $urandom;
        SLAVE_WR_ADDR_BURST = 2'($urandom_range(0, 3));
        for (k = 0; k < 50 && !SLAVE_WR_ADDR_READY; k++) @(negedge clk);
        chk("aw_ready_wait", {63'd0, SLAVE_WR_ADDR_READY}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        SLAVE_WR_ADDR_VALID = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                SLAVE_WR_DATA_VALID = 1'b0;
                @(negedge clk);
            end
            SLAVE_WR_DATA_VALID = 1'b1;
            SLAVE_WR_DATA_LAST  = (i == nbeats - 1);
            SLAVE_WR_DATA       = $urandom;
            SLAVE_WR_STRB       = 4'($urandom_range(0, 15));
            for (k = 0; k < 50 && !SLAVE_WR_DATA_READY; k++) @(negedge clk);
            chk("w_ready_wait", {63'd0, SLAVE_WR_DATA_READY}, 64'd1);
            @(posedge clk);
            @(negedge clk);
        end
        SLAVE_WR_DATA_VALID = 1'b0;
        SLAVE_WR_DATA_LAST  = 1'b0;
        err_model = err_model | (nbeats != int'(len) + 1);
        chk("b_valid", {63'd0, SLAVE_WR_BACK_VALID}, 64'd1);
        chk("b_id", {60'd0, SLAVE_WR_BACK_ID}, {60'd0, id});
        chk("b_resp", {62'd0, SLAVE_WR_BACK_RESP}, 64'd3);
        chk("wr_len_err", {63'd0, WR_LEN_ERR}, {63'd0, err_model});
        for (int d = 0; d < bdelay; d++) begin
            @(negedge clk);
            chk("b_hold", {57'd0, SLAVE_WR_BACK_VALID, SLAVE_WR_BACK_ID, SLAVE_WR_BACK_RESP},
                {57'd0, 1'b1, id, 2'b11});
        end
        SLAVE_WR_BACK_READY = 1'b1;
        @(posedge clk);
        @(negedge clk);
        SLAVE_WR_BACK_READY = 1'b0;
        chk("b_done", {62'd0, SLAVE_WR_BACK_VALID, SLAVE_WR_ADDR_READY}, 64'd1);
    endtask

    // Read burst: expect exactly len+1 zero-data DECERR beats, LAST on the final one.
    task automatic do_read(input logic [3:0] id, input logic [7:0] len, input bit stall);
        int k;
        int beat = 0;
        int cyc = 0;
        bit rr;
        @(negedge clk);
        SLAVE_RD_ADDR_VALID = 1'b1;
        SLAVE_RD_ADDR_ID    = id;
        SLAVE_RD_ADDR_LEN   = len;
        SLAVE_RD_ADDR       = $urandom;
        SLAVE_RD_ADDR_BURST = 2'($urandom_range(0, 3));
        for (k = 0; k < 50 && !SLAVE_RD_ADDR_READY; k++) @(negedge clk);
        chk("ar_ready_wait", {63'd0, SLAVE_RD_ADDR_READY}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        SLAVE_RD_ADDR_VALID = 1'b0;
        while (beat <= int'(len) && cyc < 2000) begin
            chk("r_beat", {SLAVE_RD_DATA, 25'd0, SLAVE_RD_DATA_VALID, SLAVE_RD_BACK_ID,
                           SLAVE_RD_DATA_RESP, SLAVE_RD_DATA_LAST},
                {32'd0, 25'd0, 1'b1, id, 2'b11, (beat == int'(len))});
            rr = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            SLAVE_RD_DATA_READY = rr;
            @(posedge clk);
            @(negedge clk);
            if (rr) beat++;
            cyc++;
        end
        SLAVE_RD_DATA_READY = 1'b0;
        chk("r_beats_total", 64'(beat), 64'(int'(len) + 1));
        chk("r_done", {62'd0, SLAVE_RD_DATA_VALID, SLAVE_RD_ADDR_READY}, 64'd1);
    endtask

    initial begin
        @(negedge clk);
        chk("reset_outs_0", all_outs(), 64'd0);
        @(negedge clk);
        chk("reset_outs_1", all_outs(), 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("idle_readys", {62'd0, SLAVE_WR_ADDR_READY, SLAVE_RD_ADDR_READY}, 64'd3);

        // W beats presented with no AW must stall
        SLAVE_WR_DATA_VALID = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("w_stall_idle", {63'd0, SLAVE_WR_DATA_READY}, 64'd0);
        SLAVE_WR_DATA_VALID = 1'b0;

        do_write(4'd5, 8'd3, 4, 0);
        do_read(4'd9, 8'd0, 1'b0);
        do_read(4'd2, 8'd255, 1'b1);
        for (int i = 0; i < 4; i++)
            do_read(4'($urandom_range(0, 15)), 8'($urandom_range(0, 12)), i[0]);

        do_write(4'd7, 8'd3, 2, 0);
        do_write(4'd1, 8'd1, 2, 2);

        for (int i = 0; i < 5; i++) begin
            logic [7:0] l;
            int nb;
            l  = 8'($urandom_range(0, 7));
            nb = ($urandom_range(0, 1) == 1) ? int'(l) + 1 : $urandom_range(1, 9);
            do_write(4'($urandom_range(0, 15)), l, nb, $urandom_range(0, 3));
        end

        fork
            do_write(4'd12, 8'd1, 2, 10);
            do_read(4'd6, 8'd3, 1'b0);
        join

        // Reset in the middle of an 8-beat read, after two beats
        @(negedge clk);
        SLAVE_RD_ADDR_VALID = 1'b1;
        SLAVE_RD_ADDR_ID    = 4'd3;
        SLAVE_RD_ADDR_LEN   = 8'd7;
        @(posedge clk);
        @(negedge clk);
        SLAVE_RD_ADDR_VALID = 1'b0;
        SLAVE_RD_DATA_READY = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        SLAVE_RD_DATA_READY = 1'b0;
        chk("mid_burst_valid", {62'd0, SLAVE_RD_DATA_VALID, SLAVE_RD_DATA_LAST}, 64'd2);
        #1;
        rstn = 1'b0;
        #1;
        chk("async_reset_outs", all_outs(), 64'd0);
        err_model = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        do_read(4'd4, 8'd3, 1'b0);
        do_write(4'd8, 8'd2, 3, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
